// File: rtl/riscv_alu_issue_pkg.sv
// Shared configuration for the execute issue path.
// Holds the data width, the RV32I major opcodes, the ALU control encoding
// (shared with the ALU itself), the operand-select codes, and a helper that
// maps funct3 plus the alternate bit onto an ALU operation.
package riscv_alu_issue_pkg;

  localparam int XLEN = 32;

  // RV32I major opcodes, instruction[6:0].
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU control encoding; the ALU decodes exactly these values.
  typedef enum logic [3:0] {
    ALU_CTRL_ADD  = 4'd0,
    ALU_CTRL_SUB  = 4'd1,
    ALU_CTRL_SLL  = 4'd2,
    ALU_CTRL_SLT  = 4'd3,
    ALU_CTRL_SLTU = 4'd4,
    ALU_CTRL_XOR  = 4'd5,
    ALU_CTRL_SRL  = 4'd6,
    ALU_CTRL_SRA  = 4'd7,
    ALU_CTRL_OR   = 4'd8,
    ALU_CTRL_AND  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    A_SEL_ZERO,
    A_SEL_RS1,
    A_SEL_PC
  } a_sel_e;

  typedef enum logic [1:0] {
    B_SEL_ZERO,
    B_SEL_RS2,
    B_SEL_IMM,
    B_SEL_FOUR
  } b_sel_e;

  // One buffered issue entry as seen by the ALU / execute stage.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_ctrl_e       ctrl;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic            illegal;
  } issue_entry_t;

  // Register/immediate arithmetic map. 'alt' selects SUB for funct3 000 and
  // SRA for funct3 101; callers decide when the alternate bit is meaningful.
  function automatic alu_ctrl_e arith_ctrl(input logic [2:0] funct3,
                                           input logic       alt);
    alu_ctrl_e c;
    c = ALU_CTRL_ADD;
    case (funct3)
      3'b000: c = alt ? ALU_CTRL_SUB : ALU_CTRL_ADD;
      3'b001: c = ALU_CTRL_SLL;
      3'b010: c = ALU_CTRL_SLT;
      3'b011: c = ALU_CTRL_SLTU;
      3'b100: c = ALU_CTRL_XOR;
      3'b101: c = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
      3'b110: c = ALU_CTRL_OR;
      3'b111: c = ALU_CTRL_AND;
      default: c = ALU_CTRL_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/riscv_alu_ctrl_dec.sv
// Combinational ALU control decoder.
// Maps opcode / funct3 / funct7[5] onto an ALU operation, the A and B
// operand selects, and an illegal flag. Stateless so other stages can reuse it.
//   opcode, funct3, funct7_5 : instruction fields
//   ctrl                     : ALU control code
//   a_sel, b_sel             : operand source selects
//   illegal                  : opcode or branch funct3 not supported
module riscv_alu_ctrl_dec
  import riscv_alu_issue_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_ctrl_e  ctrl,
  output a_sel_e     a_sel,
  output b_sel_e     b_sel,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl    = ALU_CTRL_ADD;
    a_sel   = A_SEL_ZERO;
    b_sel   = B_SEL_ZERO;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_sel = A_SEL_RS1;
        b_sel = B_SEL_RS2;
        ctrl  = arith_ctrl(funct3, funct7_5);
      end
      OPC_OPIMM: begin
        // There is no SUBI: funct7[5] only distinguishes SRAI from SRLI.
        a_sel = A_SEL_RS1;
        b_sel = B_SEL_IMM;
        ctrl  = arith_ctrl(funct3, funct7_5 && (funct3 == 3'b101));
      end
      OPC_LUI: begin
        b_sel = B_SEL_IMM;
      end
      OPC_AUIPC: begin
        a_sel = A_SEL_PC;
        b_sel = B_SEL_IMM;
      end
      OPC_LOAD, OPC_STORE: begin
        a_sel = A_SEL_RS1;
        b_sel = B_SEL_IMM;
      end
      OPC_BRANCH: begin
        // funct3[2:1] picks the comparison; 01x has no branch encoding.
        case (funct3[2:1])
          2'b00: begin a_sel = A_SEL_RS1; b_sel = B_SEL_RS2; ctrl = ALU_CTRL_SUB;  end
          2'b10: begin a_sel = A_SEL_RS1; b_sel = B_SEL_RS2; ctrl = ALU_CTRL_SLT;  end
          2'b11: begin a_sel = A_SEL_RS1; b_sel = B_SEL_RS2; ctrl = ALU_CTRL_SLTU; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU produces the link value pc + 4.
        a_sel = A_SEL_PC;
        b_sel = B_SEL_FOUR;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_alu_issue.sv
// Execute-side issue stage.
// Accepts decoded fields from decode over valid/ready, builds the ALU
// operands and control code, and holds them in a 2-entry skid buffer so that
// o_id_ready is a register and never follows i_ex_ready combinationally.
//   i_clk, i_rstn       : clock, synchronous active-low reset
//   i_flush             : drop every buffered entry and the current input
//   i_id_* / o_id_ready : decode-side handshake and instruction fields
//   o_ex_valid / i_ex_ready : execute-side handshake on the head entry
//   o_alu_a/b/ctrl, o_ex_rd, o_ex_opcode, o_ex_illegal : head entry payload
module riscv_alu_issue
  import riscv_alu_issue_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [6:0]      i_id_opcode,
  input  logic [2:0]      i_id_funct3,
  input  logic            i_id_funct7_5,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [4:0]      i_id_rd,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  output logic [4:0]      o_ex_rd,
  output logic [6:0]      o_ex_opcode,
  output logic            o_ex_illegal
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FULL,
    S_SKID
  } buf_state_e;

  localparam issue_entry_t ENTRY_RESET = '{
    a: '0, b: '0, ctrl: ALU_CTRL_ADD, rd: '0, opcode: '0, illegal: 1'b0
  };

  buf_state_e   state;
  issue_entry_t head;
  issue_entry_t skid;
  issue_entry_t in_entry;

  alu_ctrl_e dec_ctrl;
  a_sel_e    dec_a_sel;
  b_sel_e    dec_b_sel;
  logic      dec_illegal;

  logic accept;
  logic pop;

  riscv_alu_ctrl_dec u_dec (
    .opcode   (i_id_opcode),
    .funct3   (i_id_funct3),
    .funct7_5 (i_id_funct7_5),
    .ctrl     (dec_ctrl),
    .a_sel    (dec_a_sel),
    .b_sel    (dec_b_sel),
    .illegal  (dec_illegal)
  );

  // Operand muxes: build the entry that would be written on accept.
  always_comb begin
    in_entry         = ENTRY_RESET;
    in_entry.ctrl    = dec_ctrl;
    in_entry.rd      = i_id_rd;
    in_entry.opcode  = i_id_opcode;
    in_entry.illegal = dec_illegal;
    case (dec_a_sel)
      A_SEL_RS1: in_entry.a = i_id_rs1_data;
      A_SEL_PC:  in_entry.a = i_id_pc;
      default:   in_entry.a = '0;
    endcase
    case (dec_b_sel)
      B_SEL_RS2:  in_entry.b = i_id_rs2_data;
      B_SEL_IMM:  in_entry.b = i_id_imm;
      B_SEL_FOUR: in_entry.b = XLEN'(4);
      default:    in_entry.b = '0;
    endcase
  end

  assign accept = i_id_valid & o_id_ready;
  assign pop    = o_ex_valid & i_ex_ready;

  // Buffer FSM. o_id_ready and o_ex_valid are registered alongside the state
  // so neither is a decode of anything combinational.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      // NOTE: non-blocking assignments throughout sequential logic so every flop samples pre-edge values.
      state      <= S_EMPTY;
      o_ex_valid <= 1'b0;
      o_id_ready <= 1'b1;
      // The head drives the outputs directly, so it is cleared to show reset values.
      head       <= ENTRY_RESET;
    end else if (i_flush) begin
      state      <= S_EMPTY;
      o_ex_valid <= 1'b0;
      o_id_ready <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            head       <= in_entry;
            state      <= S_FULL;
            o_ex_valid <= 1'b1;
          end
        end
        S_FULL: begin
          if (accept && pop) begin
            head <= in_entry;
          end else if (accept) begin
            state      <= S_SKID;
            o_id_ready <= 1'b0;
          end else if (pop) begin
            state      <= S_EMPTY;
            o_ex_valid <= 1'b0;
          end
        end
        S_SKID: begin
          if (pop) begin
            head       <= skid;
            state      <= S_FULL;
            o_id_ready <= 1'b1;
          end
        end
        default: begin
          state      <= S_EMPTY;
          o_ex_valid <= 1'b0;
          o_id_ready <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the skid payload has no reset; its contents are only read once the state says it is valid.
  always_ff @(posedge i_clk) begin
    if (i_rstn && !i_flush && (state == S_FULL) && accept && !pop) begin
      skid <= in_entry;
    end
  end

  assign o_alu_a      = head.a;
  assign o_alu_b      = head.b;
  assign o_alu_ctrl   = head.ctrl;
  assign o_ex_rd      = head.rd;
  assign o_ex_opcode  = head.opcode;
  assign o_ex_illegal = head.illegal;

endmodule

// File: doc/riscv_alu_issue.md
# riscv_alu_issue

Execute-side issue stage that drives the ALU operand/control interface. It accepts decoded instruction fields and register-file data from the decode stage over a valid/ready handshake, and derives the ALU control code and operand selection from opcode/funct fields. Results go into a 2-entry registered skid buffer that feeds the ALU and execute stage. It sits between decode and the combinational ALU, and absorbs execute-side back-pressure without a combinational ready path to decode.

## Interface
- `XLEN`: taken from `riscv_configs.v` (32). Data width of operands and PC.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rstn`  in  1  reset; synchronous, active-low.
- `i_flush`  in  1  synchronous kill of all buffered entries.
- `i_id_valid`  in  1  decode presents an instruction.
- `o_id_ready`  out  1  stage can accept; registered, reset value 1.
- `i_id_opcode`  in  7  instruction[6:0].
- `i_id_funct3`  in  3  instruction[14:12].
- `i_id_funct7_5`  in  1  instruction[30].
- `i_id_pc`, `i_id_rs1_data`, `i_id_rs2_data`, `i_id_imm`  in  XLEN  PC, register operands, sign-extended immediate.
- `i_id_rd`  in  5  destination register.
- `o_ex_valid`  out  1  head entry valid; reset 0.
- `i_ex_ready`  in  1  execute consumes head entry.
- `o_alu_a`, `o_alu_b`  out  XLEN  ALU operands; reset 0.
- `o_alu_ctrl`  out  4  ALU control code (`ALU_CTRL_*`); reset `ALU_CTRL_ADD`.
- `o_ex_rd`  out  5  destination; reset 0.
- `o_ex_opcode`  out  7  passed-through opcode; reset 0.
- `o_ex_illegal`  out  1  unsupported opcode flag; reset 0.

## Operation
- Decode (accept cycle, combinational on `i_id_*`):
  - OP 0110011: a=rs1, b=rs2. funct3 000 gives ADD, or SUB if funct7_5. 001 gives SLL, 010 SLT, 011 SLTU, 100 XOR. 101 gives SRL, or SRA if funct7_5. 110 gives OR, 111 AND.
  - OP-IMM 0010011: same map with b=imm, except funct3 000 is always ADD. funct7_5 is honoured only for funct3 101.
  - LUI 0110111: a=0, b=imm, ADD.
  - AUIPC 0010111: a=pc, b=imm, ADD.
  - LOAD 0000011 / STORE 0100011: a=rs1, b=imm, ADD.
  - BRANCH 1100011: a=rs1, b=rs2. funct3 00x gives SUB. 10x gives SLT. 11x gives SLTU. 01x is illegal.
  - JAL 1101111 / JALR 1100111: a=pc, b=4, ADD (link value).
  - Anything else: illegal=1, ctrl=ADD, a=b=0. The entry still flows; it is not dropped.
- Buffer states:
  - EMPTY: no valid entry.
  - FULL: head entry valid.
  - SKID: head and skid entries valid.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL: accept with pop stays FULL. Accept without pop goes to SKID. Pop without accept goes to EMPTY.
  - SKID: on pop, the skid entry moves to head and the state becomes FULL. No accept is possible in SKID.
- Accept = `i_id_valid & o_id_ready`. Pop = `o_ex_valid & i_ex_ready`.
- `o_id_ready` = 1 in EMPTY and FULL, 0 in SKID. It is driven from a register and never depends on `i_ex_ready` in the same cycle.
- Ordering is strictly FIFO. No entry is duplicated or lost under any valid/ready pattern.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on `o_ex_*`/`o_alu_*` after edge N when the buffer was EMPTY, or when it was FULL with a pop.
- Head outputs hold stable while `o_ex_valid & !i_ex_ready`.
- Flush has priority over accept and pop. On the next edge the state is EMPTY, `o_ex_valid`=0 and `o_id_ready`=1. An instruction presented in the flush cycle is discarded.
- Reset (`!i_rstn` at edge) has priority over flush. All outputs take the reset values listed in the Interface section. This holds mid-stream as well: buffered entries are lost.
- Payload registers need no reset. Only the valid/state bits are reset, but outputs must read as reset values while EMPTY after reset.

## Structure
- `ALU_CTRL_*` codes, `XLEN`, and opcode constants (`OPC_OP`, `OPC_OPIMM`, `OPC_LUI`, `OPC_AUIPC`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`) live in `riscv_configs.v`. The ALU shares the same control encoding.
- Sub-module `riscv_alu_ctrl_dec`: purely combinational decode (opcode, funct3, funct7_5 to ctrl, a-select, b-select, illegal). It is reusable by other stages.
- The top holds the operand muxes, the 2-entry skid buffer and its state register.

## Test plan
- OP ADD: rs1=5, rs2=7, funct3=000, funct7_5=0, accepted with ex_ready=1 → next cycle valid=1, ctrl=ADD, a=5, b=7.
- OP-IMM SRAI: funct3=101, funct7_5=1, rs1=0x80000000, imm=0x404 → ctrl=SRA, a=0x80000000, b=0x404. Also funct3=000 with funct7_5=1 → ctrl=ADD.
- AUIPC/JAL: pc=0x1000, imm=0x2000 → AUIPC gives a=0x1000, b=0x2000, ADD. JAL gives a=0x1000, b=4, ADD.
- Back-pressure: three back-to-back instructions with ex_ready=0 → o_id_ready=0 after the second is accepted, third held at decode. Releasing ex_ready yields all three in order with no gaps or duplicates.
- Flush in SKID: i_flush=1 with ex_ready=0 and id_valid=1 → next cycle o_ex_valid=0, o_id_ready=1, and the flushed input never appears.
- Illegal/reset: opcode 0x7F → illegal=1, ctrl=ADD, a=b=0. Asserting i_rstn=0 while FULL → next cycle all outputs at reset values.
